// File: rtl/shader_pkg.sv
// Shared types and constants for the shader instruction store: instruction
// word, NOP encoding, built-in default program and loader FSM states.
package shader_pkg;

  typedef logic [7:0] instr_t;

  localparam instr_t NOP_INSTR        = 8'b01_00_00_00;
  localparam int     DEFAULT_PROG_LEN = 6;

  // GETX R0, GETY R1, XOR R0 R1, GETTIME R2, ADD R0 R2, SETRGB R0
  localparam instr_t DEFAULT_PROG [DEFAULT_PROG_LEN] =
    '{8'h10, 8'h15, 8'h74, 8'h1A, 8'h98, 8'h00};

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_FILL    = 2'd1,
    LD_FULL    = 2'd2,
    LD_PENDING = 2'd3
  } ld_state_e;

  function automatic instr_t default_word(input int idx);
    instr_t w;
    w = NOP_INSTR;
    for (int i = 0; i < DEFAULT_PROG_LEN; i++) begin
      if (i == idx) begin
        w = DEFAULT_PROG[i];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/shader_prog_loader.sv
// Shadow-bank loader: counts streamed words, holds a commit until the
// frame-boundary strobe and then issues a single-cycle swap.
module shader_prog_loader
  import shader_pkg::*;
#(
  parameter  int DEPTH  = 10,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_valid_i,
  input  logic              prog_commit_i,
  input  logic              swap_at_i,
  output logic              prog_ready_o,
  output logic              swap_pending_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              swap_o,
  output logic [ADDR_W:0]   wr_cnt_o
);

  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

  ld_state_e       state_q, state_d;
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;

  // Loader state and word counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LD_IDLE;
      wr_cnt_q <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Next-state, write strobe and swap decode; a handshake coinciding with a
  // commit is counted before the commit takes effect.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    wr_en_o  = 1'b0;
    swap_o   = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (prog_valid_i) begin
          wr_en_o  = 1'b1;
          wr_cnt_d = CNT_ONE;
          state_d  = LD_FILL;
        end else begin
          state_d  = LD_IDLE;
        end
      end
      LD_FILL: begin
        if (prog_valid_i) begin
          wr_en_o  = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
        if (prog_commit_i) begin
          state_d = LD_PENDING;
        end else if (wr_cnt_d == CNT_DEPTH) begin
          state_d = LD_FULL;
        end else begin
          state_d = LD_FILL;
        end
      end
      LD_FULL: begin
        if (prog_commit_i) begin
          state_d = LD_PENDING;
        end else begin
          state_d = LD_FULL;
        end
      end
      LD_PENDING: begin
        if (swap_at_i) begin
          swap_o   = 1'b1;
          wr_cnt_d = {(ADDR_W+1){1'b0}};
          state_d  = LD_IDLE;
        end else begin
          state_d  = LD_PENDING;
        end
      end
      default: begin
        wr_cnt_d = {(ADDR_W+1){1'b0}};
        state_d  = LD_IDLE;
      end
    endcase
  end

  assign prog_ready_o   = (state_q == LD_IDLE) || (state_q == LD_FILL);
  assign swap_pending_o = (state_q == LD_PENDING);
  assign wr_addr_o      = wr_cnt_q[ADDR_W-1:0];
  assign wr_cnt_o       = wr_cnt_q;

endmodule

// File: rtl/shader_program_store.sv
// Double-buffered shader instruction store: active bank read at a wrapping PC,
// shadow bank streamed in and swapped at a frame boundary.
// Define SHADER_DEFAULT_PROG_EN to boot bank 0 with the built-in program.
module shader_program_store
  import shader_pkg::*;
#(
  parameter  int INSTR_W = 8,
  parameter  int DEPTH   = 10,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exec_next_i,
  input  logic               exec_restart_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  input  logic               prog_valid_i,
  input  logic [INSTR_W-1:0] prog_data_i,
  output logic               prog_ready_o,
  input  logic               prog_commit_i,
  input  logic               swap_at_i,
  output logic               swap_pending_o,
  output logic               active_bank_o,
  output logic [ADDR_W:0]    active_len_o
);

`ifdef SHADER_DEFAULT_PROG_EN
  localparam bit DEFAULT_EN = 1'b1;
`else
  localparam bit DEFAULT_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] RESET_LEN =
    DEFAULT_EN ? (ADDR_W+1)'(DEFAULT_PROG_LEN) : (ADDR_W+1)'(DEPTH);

  if (DEPTH < 2) begin : g_depth_err
    $error("shader_program_store: DEPTH must be at least 2");
  end
  if (DEFAULT_EN && (DEPTH < DEFAULT_PROG_LEN)) begin : g_prog_err
    $error("shader_program_store: DEPTH too small for the default program");
  end

  logic [INSTR_W-1:0] bank_q [2][DEPTH];
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               active_bank_q, active_bank_d;
  logic [ADDR_W:0]    active_len_q, active_len_d;

  logic               wr_en_s;
  logic [ADDR_W-1:0]  wr_addr_s;
  logic               swap_s;
  logic [ADDR_W:0]    wr_cnt_s;

  shader_prog_loader #(.DEPTH(DEPTH)) u_loader (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .prog_valid_i  (prog_valid_i),
    .prog_commit_i (prog_commit_i),
    .swap_at_i     (swap_at_i),
    .prog_ready_o  (prog_ready_o),
    .swap_pending_o(swap_pending_o),
    .wr_en_o       (wr_en_s),
    .wr_addr_o     (wr_addr_s),
    .swap_o        (swap_s),
    .wr_cnt_o      (wr_cnt_s)
  );

  // PC, bank select and length; a swap outranks restart, which outranks next.
  always_comb begin
    pc_d          = pc_q;
    active_bank_d = active_bank_q;
    active_len_d  = active_len_q;
    if (swap_s) begin
      pc_d          = {ADDR_W{1'b0}};
      active_bank_d = ~active_bank_q;
      active_len_d  = wr_cnt_s;
    end else if (exec_restart_i) begin
      pc_d = {ADDR_W{1'b0}};
    end else if (exec_next_i) begin
      if ({1'b0, pc_q} == (active_len_q - LEN_ONE)) begin
        pc_d = {ADDR_W{1'b0}};
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Execution state and both banks; loads always target the inactive bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= {ADDR_W{1'b0}};
      active_bank_q <= 1'b0;
      active_len_q  <= RESET_LEN;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[0][i] <= DEFAULT_EN ? INSTR_W'(default_word(i)) : INSTR_W'(NOP_INSTR);
        bank_q[1][i] <= INSTR_W'(NOP_INSTR);
      end
    end else begin
      pc_q          <= pc_d;
      active_bank_q <= active_bank_d;
      active_len_q  <= active_len_d;
      if (wr_en_s) begin
        bank_q[~active_bank_q][wr_addr_s] <= prog_data_i;
      end
    end
  end

  assign instr_o       = bank_q[active_bank_q][pc_q];
  assign pc_o          = pc_q;
  assign active_bank_o = active_bank_q;
  assign active_len_o  = active_len_q;

endmodule

// File: tb/tb_shader_program_store.sv
// Directed self-checking bench for shader_program_store (DEPTH = 10).
module tb_shader_program_store;

  logic       clk_i = 1'b0;
  logic       rst_i, exec_next_i, exec_restart_i;
  logic [7:0] instr_o;
  logic [3:0] pc_o;
  logic       prog_valid_i;
  logic [7:0] prog_data_i;
  logic       prog_ready_o, prog_commit_i, swap_at_i, swap_pending_o, active_bank_o;
  logic [4:0] active_len_o;

  int checks = 0;
  int errors = 0;

`ifdef SHADER_DEFAULT_PROG_EN
  localparam int RST_LEN = 6;
`else
  localparam int RST_LEN = 10;
`endif

  shader_program_store dut (
    .clk_i(clk_i), .rst_i(rst_i), .exec_next_i(exec_next_i),
    .exec_restart_i(exec_restart_i), .instr_o(instr_o), .pc_o(pc_o),
    .prog_valid_i(prog_valid_i), .prog_data_i(prog_data_i),
    .prog_ready_o(prog_ready_o), .prog_commit_i(prog_commit_i),
    .swap_at_i(swap_at_i), .swap_pending_o(swap_pending_o),
    .active_bank_o(active_bank_o), .active_len_o(active_len_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] exp_reset_word(input int i);
`ifdef SHADER_DEFAULT_PROG_EN
    case (i)
      0: return 8'h10;
      1: return 8'h15;
      2: return 8'h74;
      3: return 8'h1A;
      4: return 8'h98;
      5: return 8'h00;
      default: return 8'h40;
    endcase
`else
    return (i >= 0) ? 8'h40 : 8'h40;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] pc, input logic [7:0] ins,
                             input logic bank, input logic [4:0] len);
    check_eq({tag, "_pc"}, 32'(pc_o), 32'(pc));
    check_eq({tag, "_instr"}, 32'(instr_o), 32'(ins));
    check_eq({tag, "_bank"}, 32'(active_bank_o), 32'(bank));
    check_eq({tag, "_len"}, 32'(active_len_o), 32'(len));
  endtask

  initial begin
    rst_i = 1'b1; exec_next_i = 1'b0; exec_restart_i = 1'b0;
    prog_valid_i = 1'b0; prog_data_i = 8'h00; prog_commit_i = 1'b0; swap_at_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state and free-running execution of the boot program.
    check_state("reset", 4'd0, exp_reset_word(0), 1'b0, 5'(RST_LEN));
    check_eq("reset_ready", 32'(prog_ready_o), 32'd1);
    check_eq("reset_pending", 32'(swap_pending_o), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      exec_next_i = 1'b1; tick(); exec_next_i = 1'b0;
      check_eq("boot_pc", 32'(pc_o), 32'(k % RST_LEN));
      check_eq("boot_instr", 32'(instr_o), 32'(exp_reset_word(k % RST_LEN)));
    end
    exec_restart_i = 1'b1; tick(); exec_restart_i = 1'b0;
    check_eq("restart_pc", 32'(pc_o), 32'd0);

    // Three-word program, commit, swap held until the strobe.
    prog_valid_i = 1'b1;
    prog_data_i = 8'hA1; tick();
    prog_data_i = 8'hA2; tick();
    prog_data_i = 8'hA3; tick();
    prog_valid_i = 1'b0;
    check_eq("fill_ready", 32'(prog_ready_o), 32'd1);
    prog_commit_i = 1'b1; tick(); prog_commit_i = 1'b0;
    check_eq("commit_pending", 32'(swap_pending_o), 32'd1);
    check_eq("commit_ready", 32'(prog_ready_o), 32'd0);
    exec_next_i = 1'b1; tick();
    check_state("pend_exec", 4'd1, exp_reset_word(1), 1'b0, 5'(RST_LEN));
    swap_at_i = 1'b1; tick(); swap_at_i = 1'b0;
    check_state("swap3", 4'd0, 8'hA1, 1'b1, 5'd3);
    check_eq("swap3_pending", 32'(swap_pending_o), 32'd0);
    tick(); check_state("p3_1", 4'd1, 8'hA2, 1'b1, 5'd3);
    tick(); check_state("p3_2", 4'd2, 8'hA3, 1'b1, 5'd3);
    tick(); check_state("p3_wrap", 4'd0, 8'hA1, 1'b1, 5'd3);
    exec_next_i = 1'b0;

    // Full-depth load; an eleventh word must be refused.
    prog_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prog_data_i = 8'hB0 + 8'(i); tick();
      check_eq("full_ready", 32'(prog_ready_o), (i < 9) ? 32'd1 : 32'd0);
    end
    prog_data_i = 8'hCC; tick();
    check_eq("full_11th_ready", 32'(prog_ready_o), 32'd0);
    prog_valid_i = 1'b0;
    prog_commit_i = 1'b1; tick(); prog_commit_i = 1'b0;
    swap_at_i = 1'b1; tick(); swap_at_i = 1'b0;
    check_state("swap10", 4'd0, 8'hB0, 1'b0, 5'd10);
    exec_next_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_eq("p10_pc", 32'(pc_o), 32'(k % 10));
      check_eq("p10_instr", 32'(instr_o), 32'(8'hB0 + 8'(k % 10)));
    end
    exec_next_i = 1'b0;

    // Commit with nothing loaded is ignored, and so is the strobe.
    prog_commit_i = 1'b1; tick(); prog_commit_i = 1'b0;
    check_eq("empty_pending", 32'(swap_pending_o), 32'd0);
    check_eq("empty_ready", 32'(prog_ready_o), 32'd1);
    swap_at_i = 1'b1; tick(); swap_at_i = 1'b0;
    check_state("empty_swap", 4'd1, 8'hB1, 1'b0, 5'd10);

    // Last word, commit and strobe together; only a later strobe swaps.
    prog_valid_i = 1'b1; prog_data_i = 8'hD1; tick();
    prog_data_i = 8'hD2; prog_commit_i = 1'b1; swap_at_i = 1'b1; tick();
    prog_valid_i = 1'b0; prog_commit_i = 1'b0; swap_at_i = 1'b0;
    check_eq("same_pending", 32'(swap_pending_o), 32'd1);
    check_state("same_noswap", 4'd1, 8'hB1, 1'b0, 5'd10);
    tick();
    check_eq("same_hold", 32'(swap_pending_o), 32'd1);
    swap_at_i = 1'b1; tick(); swap_at_i = 1'b0;
    check_state("late_swap", 4'd0, 8'hD1, 1'b1, 5'd2);
    exec_next_i = 1'b1;
    tick(); check_state("p2_1", 4'd1, 8'hD2, 1'b1, 5'd2);
    tick(); check_state("p2_wrap", 4'd0, 8'hD1, 1'b1, 5'd2);
    exec_next_i = 1'b0;

    // Reset in the middle of a load.
    prog_valid_i = 1'b1;
    prog_data_i = 8'hE1; tick();
    prog_data_i = 8'hE2; tick();
    prog_valid_i = 1'b0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check_eq("mid_rst_ready", 32'(prog_ready_o), 32'd1);
    check_eq("mid_rst_pending", 32'(swap_pending_o), 32'd0);
    check_state("mid_rst", 4'd0, exp_reset_word(0), 1'b0, 5'(RST_LEN));
    prog_commit_i = 1'b1; tick(); prog_commit_i = 1'b0;
    check_eq("mid_rst_commit", 32'(swap_pending_o), 32'd0);
    swap_at_i = 1'b1; exec_next_i = 1'b1; tick(); swap_at_i = 1'b0; exec_next_i = 1'b0;
    check_state("mid_rst_swap", 4'd1, exp_reset_word(1), 1'b0, 5'(RST_LEN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
